bidiag_collector: RTL

BIDIAG_COLLECTOR -- requirements
Module: bidiag_collector

---
 rtl/bidiag_pkg.sv | 35 +++
 rtl/bidiag_bank.sv | 52 +++++
 rtl/bidiag_collector.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bidiag_pkg.sv
// ============================================================================
// Module      : bidiag_pkg
// Description : Shared definitions for the bidiagonal matrix collector:
//               default widths, read-FSM state encoding and the helper that
//               maps an output word number to a bank entry.
//               Optional macro BIDIAG_TRANSPOSE_EN selects column-major
//               readout. When it is undefined, readout is row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bidiag_pkg;

  localparam int BIT_NUM      = 18;   // signed width of one real/imag part
  localparam int CHANNEL_SIZE = 16;   // complex entries in one 4x4 matrix
  localparam int ADDR_W       = $clog2(CHANNEL_SIZE);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Output word k -> bank entry. A 4x4 transpose swaps the row and column
  // halves of the index: entry (k%4)*4 + k/4.
  function automatic logic [ADDR_W-1:0] out_index(input logic [ADDR_W-1:0] k);
`ifdef BIDIAG_TRANSPOSE_EN
    return {k[1:0], k[3:2]};
`else
    return k;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/bidiag_bank.sv
// ============================================================================
// Module      : bidiag_bank
// Description : Two ping-pong banks of CHANNEL_SIZE complex entries held in
//               one register file. It has one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Ports       : clk        - clock
//               i_we       - write enable
//               i_wr_bank  - bank selected for writing
//               i_wr_addr  - entry selected for writing
//               i_wr_re/im - write data
//               i_rd_bank  - bank selected for reading
//               i_rd_addr  - entry selected for reading
//               o_rd_re/im - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidiag_bank #(
  parameter int BIT_NUM      = bidiag_pkg::BIT_NUM,
  parameter int CHANNEL_SIZE = bidiag_pkg::CHANNEL_SIZE
) (
  input  logic                              clk,
  input  logic                              i_we,
  input  logic                              i_wr_bank,
  input  logic [$clog2(CHANNEL_SIZE)-1:0]   i_wr_addr,
  input  logic signed [BIT_NUM-1:0]         i_wr_re,
  input  logic signed [BIT_NUM-1:0]         i_wr_im,
  input  logic                              i_rd_bank,
  input  logic [$clog2(CHANNEL_SIZE)-1:0]   i_rd_addr,
  output logic signed [BIT_NUM-1:0]         o_rd_re,
  output logic signed [BIT_NUM-1:0]         o_rd_im
);

  localparam int DEPTH = 2 * CHANNEL_SIZE;

  logic signed [BIT_NUM-1:0] r_mem_re [0:DEPTH-1];
  logic signed [BIT_NUM-1:0] r_mem_im [0:DEPTH-1];

  // The bank number is the MSB of the flat address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_re[{i_wr_bank, i_wr_addr}] <= i_wr_re;
      r_mem_im[{i_wr_bank, i_wr_addr}] <= i_wr_im;
    end
  end

  assign o_rd_re = r_mem_re[{i_rd_bank, i_rd_addr}];
  assign o_rd_im = r_mem_im[{i_rd_bank, i_rd_addr}];

endmodule

`default_nettype wire

// File: rtl/bidiag_collector.sv
// ============================================================================
// Module      : bidiag_collector
// Description : Collects 4x4 complex bidiagonalized matrices. The samples
//               arrive in row-major order and have no backpressure. The
//               module stores them in two ping-pong banks. Each complete
//               matrix is sent downstream as 16 words over a valid/ready
//               handshake, with a frame start flag and a frame end flag.
//               Macro BIDIAG_TRANSPOSE_EN (optional) selects column-major
//               readout. Timing is the same in both builds.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               valid_i    - input sample strobe
//               R_i / I_i  - input real / imag
//               ready_i    - downstream accepts current word
//               R_o / I_o  - output real / imag (registered)
//               valid_o    - output word valid
//               sof_o      - first word of a matrix
//               eof_o      - last word of a matrix
//               overflow_o - sticky: a sample was dropped because no bank was free
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidiag_collector
  import bidiag_pkg::*;
#(
  parameter int BIT_NUM      = bidiag_pkg::BIT_NUM,
  parameter int CHANNEL_SIZE = bidiag_pkg::CHANNEL_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic signed [BIT_NUM-1:0] R_i,
  input  logic signed [BIT_NUM-1:0] I_i,
  input  logic                      ready_i,
  output logic signed [BIT_NUM-1:0] R_o,
  output logic signed [BIT_NUM-1:0] I_o,
  output logic                      valid_o,
  output logic                      sof_o,
  output logic                      eof_o,
  output logic                      overflow_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHANNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  // Write side
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_wr_bank;
  logic              r_overflow;
  logic              w_wr_en;

  // Read side
  rd_state_t                 r_state;
  logic [ADDR_W-1:0]         r_rd_cnt;
  logic                      r_rd_bank;
  logic                      r_valid_o;
  logic                      r_sof_o;
  logic                      r_eof_o;
  logic signed [BIT_NUM-1:0] r_re_o;
  logic signed [BIT_NUM-1:0] r_im_o;
  logic                      w_hs;
  logic                      w_last_hs;
  logic                      w_rd_bank;
  logic [ADDR_W-1:0]         w_rd_word;
  logic signed [BIT_NUM-1:0] w_rd_re;
  logic signed [BIT_NUM-1:0] w_rd_im;

  assign w_wr_en   = valid_i && !r_full[r_wr_bank];
  assign w_hs      = r_valid_o && ready_i;
  assign w_last_hs = w_hs && (r_rd_cnt == LAST_IDX);

  // The two banks can never be the write target and the read source at the
  // same time, so a set and a clear on the same edge always hit different bits.
  always_comb begin
    w_full_nxt = r_full;
    if (w_last_hs) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_wr_en && (r_wr_cnt == LAST_IDX)) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full     <= '0;
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (valid_i) begin
        if (r_full[r_wr_bank]) begin
          r_overflow <= 1'b1;
        end else if (r_wr_cnt == LAST_IDX) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + ONE;
        end
      end
    end
  end

  // Select the word that the output register loads next. If no word is
  // presented, load word 0 of rd_bank. After word 15, load word 0 of the
  // other bank. In all other cases, load the next word of the same bank.
  always_comb begin
    w_rd_bank = r_rd_bank;
    w_rd_word = '0;
    if (r_valid_o) begin
      if (r_rd_cnt == LAST_IDX) begin
        w_rd_bank = ~r_rd_bank;
      end else begin
        w_rd_word = r_rd_cnt + ONE;
      end
    end
  end

  bidiag_bank #(
    .BIT_NUM      (BIT_NUM),
    .CHANNEL_SIZE (CHANNEL_SIZE)
  ) u_bank (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (r_wr_cnt),
    .i_wr_re   (R_i),
    .i_wr_im   (I_i),
    .i_rd_bank (w_rd_bank),
    .i_rd_addr (out_index(w_rd_word)),
    .o_rd_re   (w_rd_re),
    .o_rd_im   (w_rd_im)
  );

  // Read FSM. IDLE spends one cycle noticing that a bank is full. SEND then
  // loads word 0. This gives the fixed one-cycle gap between the full flag
  // being set and valid_o being asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_valid_o <= 1'b0;
      r_sof_o   <= 1'b0;
      r_eof_o   <= 1'b0;
      r_re_o    <= '0;
      r_im_o    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state  <= SEND;
            r_rd_cnt <= '0;
          end
        end
        SEND: begin
          if (!r_valid_o) begin
            r_valid_o <= 1'b1;
            r_sof_o   <= 1'b1;
            r_eof_o   <= 1'b0;
            r_rd_cnt  <= '0;
            r_re_o    <= w_rd_re;
            r_im_o    <= w_rd_im;
          end else if (w_hs) begin
            if (r_rd_cnt == LAST_IDX) begin
              r_rd_bank <= ~r_rd_bank;
              if (r_full[~r_rd_bank]) begin
                r_sof_o  <= 1'b1;
                r_eof_o  <= 1'b0;
                r_rd_cnt <= '0;
                r_re_o   <= w_rd_re;
                r_im_o   <= w_rd_im;
              end else begin
                r_valid_o <= 1'b0;
                r_sof_o   <= 1'b0;
                r_eof_o   <= 1'b0;
                r_state   <= IDLE;
              end
            end else begin
              r_sof_o  <= 1'b0;
              r_eof_o  <= (w_rd_word == LAST_IDX);
              r_rd_cnt <= w_rd_word;
              r_re_o   <= w_rd_re;
              r_im_o   <= w_rd_im;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign R_o        = r_re_o;
  assign I_o        = r_im_o;
  assign valid_o    = r_valid_o;
  assign sof_o      = r_sof_o;
  assign eof_o      = r_eof_o;
  assign overflow_o = r_overflow;

endmodule

`default_nettype wire
